// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM read arbiter.
// Holds the FSM state encoding, the requester index type and the
// requester count used by the top level and the round-robin sub-block.
package ram_arbiter_pkg;

    // Number of requesters sharing the RAM port.
    localparam int NUM_REQ = 2;

    // Width of the read-latency down-counter (latency range 1..7).
    localparam int CNT_WIDTH = 3;

    // Legacy-compatible state constants; the enum below is built on them.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Transaction FSM: arbitrate, wait for the RAM, present the response.
    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        WAIT = S_WAIT,
        RESP = S_RESP
    } state_t;

    // Index of a requester (0 or 1).
    typedef logic [0:0] req_idx_t;

    // One-hot grant vector for a given requester index.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_t idx);
        logic [NUM_REQ-1:0] onehot;
        if (idx == 1'b1) begin
            onehot = 2'b10;
        end else begin
            onehot = 2'b01;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
// The grant is combinational and only offered while i_en is high.
// The pointer remembers the last granted requester, which then has the
// lowest priority on the next tie. Reset leaves requester 1 as "last"
// so requester 0 wins the first tie.
module rr_arbiter2
    import ram_arbiter_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output req_idx_t           o_gnt_idx,
    output logic               o_gnt_any
);

    req_idx_t           r_last;
    logic [NUM_REQ-1:0] w_gnt;
    req_idx_t           w_idx;

    // Select the winner: a lone request wins, a tie goes to the requester not granted last.
    always_comb begin
        w_gnt = 2'b00;
        w_idx = 1'b0;
        if (i_en) begin
            case (i_req)
                2'b01: begin
                    w_gnt = 2'b01;
                    w_idx = 1'b0;
                end
                2'b10: begin
                    w_gnt = 2'b10;
                    w_idx = 1'b1;
                end
                2'b11: begin
                    w_idx = ~r_last;
                    w_gnt = idx_to_onehot(~r_last);
                end
                default: begin
                    w_gnt = 2'b00;
                    w_idx = 1'b0;
                end
            endcase
        end else begin
            w_gnt = 2'b00;
            w_idx = 1'b0;
        end
    end

    // Round-robin pointer: moves only when a grant is actually issued.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (w_gnt != 2'b00) begin
            r_last <= w_idx;
        end else begin
            r_last <= r_last;
        end
    end

    assign o_gnt     = w_gnt;
    assign o_gnt_idx = w_idx;
    assign o_gnt_any = (w_gnt != 2'b00);

endmodule

// File: rtl/ram_arbiter.sv
// Shares one read-only RAM port between two requesters.
// IDLE arbitrates and latches the winner's address pair, WAIT counts
// READ_LATENCY cycles and captures RAM_Q on the last one, RESP holds the
// captured data for the owner until it accepts it. One transaction is in
// flight at a time, so the minimum period is READ_LATENCY+2 cycles.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 128
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  R0_VALID,
    output logic                  R0_READY,
    input  logic [ADDR_WIDTH-1:0] R0_A0,
    input  logic [ADDR_WIDTH-1:0] R0_A1,
    output logic                  R0_QVALID,
    input  logic                  R0_QREADY,
    output logic [DATA_WIDTH-1:0] R0_Q,

    input  logic                  R1_VALID,
    output logic                  R1_READY,
    input  logic [ADDR_WIDTH-1:0] R1_A0,
    input  logic [ADDR_WIDTH-1:0] R1_A1,
    output logic                  R1_QVALID,
    input  logic                  R1_QREADY,
    output logic [DATA_WIDTH-1:0] R1_Q,

    output logic [ADDR_WIDTH-1:0] RAM_A0,
    output logic [ADDR_WIDTH-1:0] RAM_A1,
    input  logic [DATA_WIDTH-1:0] RAM_Q,

    output logic                  BUSY
);

    // Counter preload; READ_LATENCY is limited to 1..7 so it fits in 3 bits.
    localparam logic [CNT_WIDTH-1:0] LAT_INIT = CNT_WIDTH'(READ_LATENCY);

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    req_idx_t              r_owner;
    logic [ADDR_WIDTH-1:0] r_ram_a0;
    logic [ADDR_WIDTH-1:0] r_ram_a1;
    logic [DATA_WIDTH-1:0] r_resp;

    logic                  w_arb_en;
    logic [NUM_REQ-1:0]    w_req;
    logic [NUM_REQ-1:0]    w_gnt;
    req_idx_t              w_gnt_idx;
    logic                  w_gnt_any;
    logic                  w_owner_qready;
    logic                  w_capture;
    logic [ADDR_WIDTH-1:0] w_sel_a0;
    logic [ADDR_WIDTH-1:0] w_sel_a1;

    // Arbitration is only open in IDLE, and never while reset is applied,
    // so READY cannot rise during reset or while a transfer is in flight.
    assign w_arb_en = (r_state == IDLE) && !RST;
    assign w_req    = {R1_VALID, R0_VALID};

    rr_arbiter2 u_rr_arbiter2 (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_en      (w_arb_en),
        .i_req     (w_req),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_any (w_gnt_any)
    );

    // Only the owner's QREADY can close a response; the other one is ignored.
    assign w_owner_qready = (r_owner == 1'b1) ? R1_QREADY : R0_QREADY;

    // The last WAIT cycle is the one where the counter still reads 1.
    assign w_capture = (r_state == WAIT) && (r_cnt == 3'd1);

    // Route the winner's address pair towards the address registers.
    always_comb begin
        w_sel_a0 = R0_A0;
        w_sel_a1 = R0_A1;
        if (w_gnt_idx == 1'b1) begin
            w_sel_a0 = R1_A0;
            w_sel_a1 = R1_A1;
        end else begin
            w_sel_a0 = R0_A0;
            w_sel_a1 = R0_A1;
        end
    end

    // Transaction FSM and read-latency counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        r_state <= WAIT;
                        r_cnt   <= LAT_INIT;
                    end else begin
                        r_state <= IDLE;
                        r_cnt   <= r_cnt;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (w_capture) begin
                        r_state <= RESP;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                RESP: begin
                    r_cnt <= r_cnt;
                    if (w_owner_qready) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= RESP;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

    // Owner and RAM address pair are latched on grant and held until the next one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_owner  <= 1'b0;
            r_ram_a0 <= '0;
            r_ram_a1 <= '0;
        end else if (w_gnt_any) begin
            r_owner  <= w_gnt_idx;
            r_ram_a0 <= w_sel_a0;
            r_ram_a1 <= w_sel_a1;
        end else begin
            r_owner  <= r_owner;
            r_ram_a0 <= r_ram_a0;
            r_ram_a1 <= r_ram_a1;
        end
    end

    // Response register: samples RAM_Q once, on the final WAIT cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_resp <= '0;
        end else if (w_capture) begin
            r_resp <= RAM_Q;
        end else begin
            r_resp <= r_resp;
        end
    end

    assign R0_READY  = w_gnt[0];
    assign R1_READY  = w_gnt[1];
    assign R0_QVALID = (r_state == RESP) && (r_owner == 1'b0);
    assign R1_QVALID = (r_state == RESP) && (r_owner == 1'b1);
    // Both data outputs carry the same register; QVALID tells who owns it.
    assign R0_Q      = r_resp;
    assign R1_Q      = r_resp;
    assign RAM_A0    = r_ram_a0;
    assign RAM_A1    = r_ram_a1;
    assign BUSY      = (r_state != IDLE);

endmodule
